// File: rtl/instruction_loader_if.sv
// Byte-stream-in / memory-write-out bundle for the instruction loader.
// master drives start and received bytes; slave is the loader itself.
interface instruction_loader_if #(
  parameter int NBITS = 32
);
  logic             i_start;
  logic             i_rx_valid;
  logic [7:0]       i_rx_byte;
  logic             o_wr_en;
  logic [NBITS-1:0] o_wr_addr;
  logic [NBITS-1:0] o_wr_data;
  logic             o_busy;
  logic             o_done;
  logic             o_full;
  logic [NBITS-1:0] o_word_count;

  modport master (
    output i_start, i_rx_valid, i_rx_byte,
    input  o_wr_en, o_wr_addr, o_wr_data,
    input  o_busy, o_done, o_full, o_word_count
  );

  modport slave (
    input  i_start, i_rx_valid, i_rx_byte,
    output o_wr_en, o_wr_addr, o_wr_data,
    output o_busy, o_done, o_full, o_word_count
  );
endinterface

// File: rtl/instruction_loader.sv
// Assembles big-endian words from a byte stream and writes them to
// instruction memory at 0, 4, 8, ... until a halt word or memory full.
module instruction_loader #(
  parameter int               NBITS     = 32,
  parameter int               CELDAS    = 60,
  parameter logic [NBITS-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input logic           i_clk,
  input logic           i_reset,
  instruction_loader_if.slave bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RECEIVE = 2'd1;
  localparam logic [1:0] WRITE   = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam logic [NBITS-1:0] STEP  = NBITS'(4);
  localparam logic [NBITS-1:0] LIMIT = NBITS'(CELDAS - 4);

  logic [1:0]       r_state;
  logic [1:0]       r_byte_cnt;
  logic [NBITS-1:0] r_addr;
  logic [31:0]      r_word;
  logic             r_wr_en;
  logic [NBITS-1:0] r_wr_addr;
  logic [NBITS-1:0] r_wr_data;
  logic             r_busy;
  logic             r_done;
  logic             r_full;
  logic [NBITS-1:0] r_word_count;

  logic [1:0]  w_next;
  logic [31:0] w_shift;
  logic        w_halt;
  logic        w_room;

  assign w_shift = {r_word[23:0], bus.i_rx_byte};
  assign w_halt  = (r_wr_data == HALT_WORD);
  // Room for another word only if the next address still fits a full word.
  assign w_room  = !((r_addr + STEP) > LIMIT);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE, DONE: if (bus.i_start) w_next = RECEIVE;
      RECEIVE:
        if (bus.i_rx_valid && r_byte_cnt == 2'd3)
          w_next = WRITE;
      WRITE:
        w_next = (w_halt || !w_room) ? DONE : RECEIVE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_byte_cnt   <= 2'd0;
      r_addr       <= '0;
      r_word       <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_full       <= 1'b0;
      r_word_count <= '0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == RECEIVE) || (w_next == WRITE);
      r_done  <= (w_next == DONE);
      r_wr_en <= 1'b0;
      unique case (r_state)
        IDLE, DONE: begin
          if (bus.i_start) begin
            r_addr       <= '0;
            r_byte_cnt   <= 2'd0;
            r_word_count <= '0;
            r_full       <= 1'b0;
          end
        end
        RECEIVE: begin
          if (bus.i_rx_valid) begin
            r_word     <= w_shift;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_addr;
              r_wr_data <= w_shift;
            end
          end
        end
        WRITE: begin
          r_word_count <= r_word_count + NBITS'(1);
          if (w_halt) begin
            r_full <= 1'b0;
          end else if (!w_room) begin
            r_full <= 1'b1;
          end else begin
            r_addr <= r_addr + STEP;
            // A byte arriving during the write opens the next word.
            if (bus.i_rx_valid) begin
              r_word     <= w_shift;
              r_byte_cnt <= 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_wr_en      = r_wr_en;
  assign bus.o_wr_addr    = r_wr_addr;
  assign bus.o_wr_data    = r_wr_data;
  assign bus.o_busy       = r_busy;
  assign bus.o_done       = r_done;
  assign bus.o_full       = r_full;
  assign bus.o_word_count = r_word_count;

endmodule

// File: tb/tb_instruction_loader.sv
// Randomized bench for instruction_loader with a word-list reference model
// and a monitor that records every write strobe.
module tb_instruction_loader;
  localparam int          NBITS  = 32;
  localparam int          CELDAS = 60;
  localparam logic [31:0] HALT   = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instruction_loader_if #(.NBITS(NBITS)) bus ();

  instruction_loader #(
    .NBITS(NBITS), .CELDAS(CELDAS), .HALT_WORD(HALT)
  ) dut (
    .i_clk(clk), .i_reset(rst), .bus(bus)
  );

  int          total = 0;
  int          bad   = 0;
  logic [63:0] got[$];
  logic [63:0] exp[$];
  logic [31:0] wq[$];
  logic        exp_full;
  int          exp_count;

  always @(posedge clk) begin
    #2;
    if (bus.o_wr_en === 1'b1)
      got.push_back({bus.o_wr_addr, bus.o_wr_data});
  end

  task automatic idle();
    @(negedge clk);
    bus.i_rx_valid = 1'b0;
    bus.i_start    = 1'b0;
  endtask

  task automatic put_byte(input logic [7:0] b);
    @(negedge clk);
    bus.i_rx_valid = 1'b1;
    bus.i_rx_byte  = b;
    bus.i_start    = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.i_start    = 1'b1;
    bus.i_rx_valid = 1'b0;
    idle();
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) begin
      put_byte(w[8*i +: 8]);
      idle();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_rx_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    w = $urandom;
    if (w == HALT) w = 32'h0;
    return w;
  endfunction

  // Expected writes: word i lands at 4*i; stop after halt or last cell.
  task automatic model();
    exp.delete();
    exp_full  = 1'b0;
    exp_count = 0;
    foreach (wq[i]) begin
      exp.push_back({32'(4 * i), wq[i]});
      exp_count++;
      if (wq[i] == HALT) return;
      if (4 * i + 8 > CELDAS) begin
        exp_full = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    total++;
    if ({bus.o_wr_en, bus.o_busy, bus.o_done, bus.o_full} !== 4'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b want 0000",
        {bus.o_wr_en, bus.o_busy, bus.o_done, bus.o_full});
    end
    total++;
    if ({bus.o_wr_addr, bus.o_wr_data, bus.o_word_count} !== 96'h0) begin
      bad++;
      $display("FAIL reset_buses: got %h want 0",
        {bus.o_wr_addr, bus.o_wr_data, bus.o_word_count});
    end
  endtask

  task automatic test_single_word();
    pulse_start();
    got.delete();
    put_byte(8'h00); idle();
    put_byte(8'h22); idle();
    put_byte(8'h10); idle();
    put_byte(8'h20); idle();
    total++;
    if ({bus.o_wr_en, bus.o_busy} !== 2'b11) begin
      bad++;
      $display("FAIL single_en_busy: got %b want 11",
        {bus.o_wr_en, bus.o_busy});
    end
    total++;
    if ({bus.o_wr_addr, bus.o_wr_data} !== {32'h0, 32'h00221020}) begin
      bad++;
      $display("FAIL single_write: got %h want %h",
        {bus.o_wr_addr, bus.o_wr_data}, {32'h0, 32'h00221020});
    end
    idle();
    total++;
    if ({bus.o_wr_en, bus.o_busy} !== 2'b01 || bus.o_word_count !== 32'd1) begin
      bad++;
      $display("FAIL single_after: got en/busy %b cnt %0d want 01 cnt 1",
        {bus.o_wr_en, bus.o_busy}, bus.o_word_count);
    end
    total++;
    if (got.size() != 1) begin
      bad++;
      $display("FAIL single_pulses: got %0d want 1", got.size());
    end
  endtask

  task automatic test_halt();
    do_reset();
    pulse_start();
    got.delete();
    wq = '{32'h00221020, 32'h8C620005, HALT};
    model();
    foreach (wq[i]) send_word(wq[i]);
    idle();
    total++;
    if ({bus.o_done, bus.o_busy, bus.o_full} !== {2'b10, exp_full}) begin
      bad++;
      $display("FAIL halt_state: got done/busy/full %b want %b",
        {bus.o_done, bus.o_busy, bus.o_full}, {2'b10, exp_full});
    end
    total++;
    if (bus.o_word_count !== 32'(exp_count)) begin
      bad++;
      $display("FAIL halt_count: got %0d want %0d",
        bus.o_word_count, exp_count);
    end
    send_word(rnd_word());
    send_word(rnd_word());
    total++;
    if (got.size() != exp.size()) begin
      bad++;
      $display("FAIL halt_nwrites: got %0d want %0d", got.size(), exp.size());
    end
    foreach (exp[i]) begin
      total++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        bad++;
        $display("FAIL halt_write%0d: got %h want %h", i,
          (i < got.size()) ? got[i] : 64'hx, exp[i]);
      end
    end
  endtask

  task automatic fill_memory();
    wq.delete();
    for (int i = 0; i < 16; i++) wq.push_back(rnd_word());
    model();
    foreach (wq[i]) send_word(wq[i]);
    idle();
  endtask

  task automatic test_full();
    do_reset();
    pulse_start();
    got.delete();
    fill_memory();
    total++;
    if ({bus.o_done, bus.o_full} !== {1'b1, exp_full}) begin
      bad++;
      $display("FAIL full_state: got done/full %b want %b",
        {bus.o_done, bus.o_full}, {1'b1, exp_full});
    end
    total++;
    if (bus.o_word_count !== 32'(exp_count)) begin
      bad++;
      $display("FAIL full_count: got %0d want %0d",
        bus.o_word_count, exp_count);
    end
    total++;
    if (got.size() != exp.size()) begin
      bad++;
      $display("FAIL full_nwrites: got %0d want %0d", got.size(), exp.size());
    end
    foreach (exp[i]) begin
      total++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        bad++;
        $display("FAIL full_write%0d: got %h want %h", i,
          (i < got.size()) ? got[i] : 64'hx, exp[i]);
      end
    end
  endtask

  task automatic test_reset_midload();
    do_reset();
    pulse_start();
    got.delete();
    put_byte(8'h12); idle();
    put_byte(8'h34); idle();
    do_reset();
    total++;
    if ({bus.o_wr_en, bus.o_busy, bus.o_done, bus.o_full} !== 4'b0 ||
        bus.o_word_count !== 32'h0 || got.size() != 0) begin
      bad++;
      $display("FAIL midreset_clear: got flags %b cnt %0d writes %0d want 0",
        {bus.o_wr_en, bus.o_busy, bus.o_done, bus.o_full},
        bus.o_word_count, got.size());
    end
    pulse_start();
    send_word(32'hAABBCCDD);
    idle();
    total++;
    if (got.size() != 1 || got[0] !== {32'h0, 32'hAABBCCDD}) begin
      bad++;
      $display("FAIL midreset_reload: got n=%0d %h want n=1 %h", got.size(),
        (got.size() > 0) ? got[0] : 64'hx, {32'h0, 32'hAABBCCDD});
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w0;
    logic [31:0] w1;
    w0 = rnd_word();
    w1 = rnd_word();
    do_reset();
    got.delete();
    for (int i = 0; i < 3; i++) begin
      put_byte(8'($urandom)); idle();
    end
    @(negedge clk);
    bus.i_start    = 1'b1;
    bus.i_rx_valid = 1'b1;
    bus.i_rx_byte  = 8'h5A;
    idle();
    put_byte(w0[31:24]); idle();
    put_byte(w0[23:16]); idle();
    pulse_start();
    put_byte(w0[15:8]); idle();
    put_byte(w0[7:0]);
    put_byte(w1[31:24]);
    idle();
    put_byte(w1[23:16]); idle();
    put_byte(w1[15:8]); idle();
    put_byte(w1[7:0]); idle();
    idle();
    wq = '{w0, w1};
    model();
    total++;
    if (got.size() != exp.size()) begin
      bad++;
      $display("FAIL b2b_nwrites: got %0d want %0d", got.size(), exp.size());
    end
    foreach (exp[i]) begin
      total++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        bad++;
        $display("FAIL b2b_write%0d: got %h want %h", i,
          (i < got.size()) ? got[i] : 64'hx, exp[i]);
      end
    end
    total++;
    if ({bus.o_busy, bus.o_done} !== 2'b10 ||
        bus.o_word_count !== 32'(exp_count)) begin
      bad++;
      $display("FAIL b2b_state: got busy/done %b cnt %0d want 10 cnt %0d",
        {bus.o_busy, bus.o_done}, bus.o_word_count, exp_count);
    end
  endtask

  task automatic test_restart();
    logic [31:0] w;
    w = rnd_word();
    do_reset();
    pulse_start();
    fill_memory();
    total++;
    if ({bus.o_done, bus.o_full} !== 2'b11) begin
      bad++;
      $display("FAIL restart_pre: got done/full %b want 11",
        {bus.o_done, bus.o_full});
    end
    got.delete();
    pulse_start();
    total++;
    if ({bus.o_done, bus.o_full, bus.o_busy} !== 3'b001 ||
        bus.o_word_count !== 32'h0) begin
      bad++;
      $display("FAIL restart_clear: got done/full/busy %b cnt %0d want 001 cnt 0",
        {bus.o_done, bus.o_full, bus.o_busy}, bus.o_word_count);
    end
    send_word(w);
    idle();
    total++;
    if (got.size() != 1 || got[0] !== {32'h0, w}) begin
      bad++;
      $display("FAIL restart_write: got n=%0d %h want n=1 %h", got.size(),
        (got.size() > 0) ? got[0] : 64'hx, {32'h0, w});
    end
  endtask

  initial begin
    bus.i_start    = 1'b0;
    bus.i_rx_valid = 1'b0;
    bus.i_rx_byte  = 8'h00;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_single_word();
    test_halt();
    test_full();
    test_reset_midload();
    test_back_to_back();
    test_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
